// File: rtl/wb_split_pkg.sv
// rtl/wb_split_pkg.sv - shared types and helpers for the Wishbone splitter
// Purpose: FSM state encoding and slave-index width helper used by
//          wb_splitter_tmo and its watchdog counter.
// Ports:   none (package)
package wb_split_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Width of the slave-index address field: clog2(n), never less than 1.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/wb_split_tmo_cnt.sv
// rtl/wb_split_tmo_cnt.sv - watchdog cycle counter for the Wishbone splitter
// Purpose: counts enabled cycles after a clear and flags when LIMIT is reached.
// Ports:   wb_clk_i, rst_n (async active-low)
//          clr     - synchronous clear to zero (has priority over en)
//          en      - count this cycle
//          expired - counter equals LIMIT (holds there until cleared)
module wb_split_tmo_cnt #(
    parameter int LIMIT = 255
) (
    input  logic wb_clk_i,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [15:0] cnt;

    assign expired = (cnt == 16'(LIMIT));

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 16'd0;
        end else if (clr) begin
            cnt <= 16'd0;
        end else if (en && !expired) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/wb_splitter_tmo.sv
// rtl/wb_splitter_tmo.sv - one-master to N-slave Wishbone splitter with optional watchdog
// Purpose: decodes the slave index from the address, forwards one transfer at a
//          time to the selected slave and returns a single-cycle ack/err.
//          Define WB_SPLITTER_TIMEOUT_EN to enable the BUSY watchdog (tmo_o).
// Ports:   wb_clk_i, rst_n (async active-low)
//          m_wb_*  - master side request in, dat/ack/err out
//          s_wb_*  - per-slave packed buses, slice k = slave k
//          tmo_o   - one-cycle pulse when the watchdog fires
module wb_splitter_tmo
    import wb_split_pkg::*;
#(
    parameter int NUM_PERIPHERALS  = 3,
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int SEL_WIDTH        = 4,
    parameter int ADDR_SEL_LOW_BIT = 16,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                                  wb_clk_i,
    input  logic                                  rst_n,
    input  logic [ADDR_WIDTH-1:0]                 m_wb_adr_i,
    input  logic [DATA_WIDTH-1:0]                 m_wb_dat_i,
    input  logic [SEL_WIDTH-1:0]                  m_wb_sel_i,
    input  logic                                  m_wb_we_i,
    input  logic                                  m_wb_cyc_i,
    input  logic                                  m_wb_stb_i,
    output logic [DATA_WIDTH-1:0]                 m_wb_dat_o,
    output logic                                  m_wb_ack_o,
    output logic                                  m_wb_err_o,
    output logic [NUM_PERIPHERALS-1:0]            s_wb_cyc_o,
    output logic [NUM_PERIPHERALS-1:0]            s_wb_stb_o,
    output logic [NUM_PERIPHERALS-1:0]            s_wb_we_o,
    output logic [NUM_PERIPHERALS*SEL_WIDTH-1:0]  s_wb_sel_o,
    output logic [NUM_PERIPHERALS*ADDR_WIDTH-1:0] s_wb_adr_o,
    output logic [NUM_PERIPHERALS*DATA_WIDTH-1:0] s_wb_dat_o,
    input  logic [NUM_PERIPHERALS*DATA_WIDTH-1:0] s_wb_dat_i,
    input  logic [NUM_PERIPHERALS-1:0]            s_wb_ack_i,
    input  logic [NUM_PERIPHERALS-1:0]            s_wb_err_i,
    output logic                                  tmo_o
);

    localparam int IDX_W = idx_width(NUM_PERIPHERALS);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [SEL_WIDTH-1:0]    sel_q;
    logic                    we_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    resp_err;

    logic [IDX_W-1:0]        req_idx;
    logic                    req;
    logic                    req_ok;
    logic                    strobing;
    logic [DATA_WIDTH-1:0]   sel_dat;
    logic                    sel_ack;
    logic                    sel_err;
    logic                    expired;

    assign req_idx  = m_wb_adr_i[ADDR_SEL_LOW_BIT +: IDX_W];
    assign req      = m_wb_cyc_i & m_wb_stb_i;
    assign req_ok   = 32'(req_idx) < 32'(NUM_PERIPHERALS);
    // Strobe goes out one cycle after entering BUSY; responses only count once it is up.
    assign strobing = |s_wb_stb_o;

    // Everything except cyc/stb is the same latched request on every slave slice.
    assign s_wb_we_o  = {NUM_PERIPHERALS{we_q}};
    assign s_wb_sel_o = {NUM_PERIPHERALS{sel_q}};
    assign s_wb_adr_o = {NUM_PERIPHERALS{adr_q}};
    assign s_wb_dat_o = {NUM_PERIPHERALS{dat_q}};

    // Pick the selected slave's response; other slaves are never looked at.
    always_comb begin
        sel_dat = '0;
        sel_ack = 1'b0;
        sel_err = 1'b0;
        for (int k = 0; k < NUM_PERIPHERALS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_dat = s_wb_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
                sel_ack = s_wb_ack_i[k];
                sel_err = s_wb_err_i[k];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            resp_err   <= 1'b0;
            s_wb_cyc_o <= '0;
            s_wb_stb_o <= '0;
            m_wb_dat_o <= '0;
            m_wb_ack_o <= 1'b0;
            m_wb_err_o <= 1'b0;
        end else begin
            m_wb_ack_o <= 1'b0;
            m_wb_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    // The response-pulse cycle is also IDLE; a master still holding
                    // stb there is finishing the old transfer, not starting a new one.
                    if (req && !m_wb_ack_o && !m_wb_err_o) begin
                        adr_q <= m_wb_adr_i;
                        dat_q <= m_wb_dat_i;
                        sel_q <= m_wb_sel_i;
                        we_q  <= m_wb_we_i;
                        idx_q <= req_idx;
                        if (req_ok) begin
                            state <= BUSY;
                        end else begin
                            resp_err   <= 1'b1;
                            m_wb_dat_o <= '0;
                            state      <= RESP;
                        end
                    end
                end
                BUSY: begin
                    if (!m_wb_cyc_i) begin
                        s_wb_cyc_o <= '0;
                        s_wb_stb_o <= '0;
                        state      <= IDLE;
                    end else if (!strobing) begin
                        s_wb_cyc_o <= NUM_PERIPHERALS'(1) << idx_q;
                        s_wb_stb_o <= NUM_PERIPHERALS'(1) << idx_q;
                    end else if (sel_ack || sel_err) begin
                        s_wb_cyc_o <= '0;
                        s_wb_stb_o <= '0;
                        resp_err   <= sel_err;
                        m_wb_dat_o <= sel_err ? '0 : sel_dat;
                        state      <= RESP;
                    end else if (expired) begin
                        s_wb_cyc_o <= '0;
                        s_wb_stb_o <= '0;
                        resp_err   <= 1'b1;
                        m_wb_dat_o <= '0;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    m_wb_ack_o <= !resp_err;
                    m_wb_err_o <= resp_err;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_SPLITTER_TIMEOUT_EN
    logic tmo_pend;

    wb_split_tmo_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_tmo_cnt (
        .wb_clk_i (wb_clk_i),
        .rst_n    (rst_n),
        .clr      (state != BUSY),
        .en       (state == BUSY),
        .expired  (expired)
    );

    // tmo_pend marks the RESP cycle of a watchdog expiry so that tmo_o lines up
    // with the m_wb_err_o pulse one edge later.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tmo_pend <= 1'b0;
            tmo_o    <= 1'b0;
        end else begin
            tmo_pend <= (state == BUSY) && m_wb_cyc_i && strobing &&
                        !sel_ack && !sel_err && expired;
            tmo_o    <= tmo_pend;
        end
    end
`else
    assign expired = 1'b0;
    assign tmo_o   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_splitter_tmo.sv
// tb/tb_wb_splitter_tmo.sv - self-checking bench for wb_splitter_tmo
module tb_wb_splitter_tmo;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic            clk;
    logic            rst_n;
    logic [AW-1:0]   m_adr;
    logic [DW-1:0]   m_dat;
    logic [SW-1:0]   m_sel;
    logic            m_we;
    logic            m_cyc;
    logic            m_stb;
    logic [DW-1:0]   m_wb_dat_o;
    logic            m_wb_ack_o;
    logic            m_wb_err_o;
    logic [NP-1:0]   s_wb_cyc_o;
    logic [NP-1:0]   s_wb_stb_o;
    logic [NP-1:0]   s_wb_we_o;
    logic [NP*SW-1:0] s_wb_sel_o;
    logic [NP*AW-1:0] s_wb_adr_o;
    logic [NP*DW-1:0] s_wb_dat_o;
    logic [NP*DW-1:0] s_dat_i;
    logic [NP-1:0]   s_ack;
    logic [NP-1:0]   s_err;
    logic            tmo_o;

    int n_chk;
    int n_err;

    wb_splitter_tmo #(
        .NUM_PERIPHERALS  (NP),
        .ADDR_WIDTH       (AW),
        .DATA_WIDTH       (DW),
        .SEL_WIDTH        (SW),
        .ADDR_SEL_LOW_BIT (16),
        .TIMEOUT_CYCLES   (16)
    ) dut (
        .wb_clk_i   (clk),
        .rst_n      (rst_n),
        .m_wb_adr_i (m_adr),
        .m_wb_dat_i (m_dat),
        .m_wb_sel_i (m_sel),
        .m_wb_we_i  (m_we),
        .m_wb_cyc_i (m_cyc),
        .m_wb_stb_i (m_stb),
        .m_wb_dat_o (m_wb_dat_o),
        .m_wb_ack_o (m_wb_ack_o),
        .m_wb_err_o (m_wb_err_o),
        .s_wb_cyc_o (s_wb_cyc_o),
        .s_wb_stb_o (s_wb_stb_o),
        .s_wb_we_o  (s_wb_we_o),
        .s_wb_sel_o (s_wb_sel_o),
        .s_wb_adr_o (s_wb_adr_o),
        .s_wb_dat_o (s_wb_dat_o),
        .s_wb_dat_i (s_dat_i),
        .s_wb_ack_i (s_ack),
        .s_wb_err_i (s_err),
        .tmo_o      (tmo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // resp: 0 = ack, 1 = err, 2 = ack and err together
    typedef struct {
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic        we;
        int          wt;
        int          resp;
        logic [31:0] rdata;
        logic [2:0]  exp_stb;
        int          exp_edge;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m_cyc = 1'b0;
        m_stb = 1'b0;
        s_ack = '0;
        s_err = '0;
    endtask

    // Runs one transfer: bench acts as master and as slave model.
    task automatic run_vec(input vec_t v, input int vi);
        int   stb_cnt;
        int   resp_edge;
        logic stb_bad;
        logic bc_bad;
        logic got_ack, got_err, got_tmo;
        logic [31:0] got_dat;
        m_adr = v.adr;
        m_dat = v.wdat;
        m_sel = v.sel;
        m_we  = v.we;
        m_cyc = 1'b1;
        m_stb = 1'b1;
        for (int k = 0; k < NP; k++)
            s_dat_i[k*DW +: DW] = v.exp_stb[k] ? v.rdata : (32'hF0F0_0000 | 32'(k));
        stb_cnt = 0; resp_edge = -1; stb_bad = 0; bc_bad = 0;
        got_ack = 0; got_err = 0; got_tmo = 0; got_dat = '0;
        for (int e = 0; e < 40 && resp_edge < 0; e++) begin
            @(posedge clk); #1;
            if (s_wb_stb_o != '0) begin
                if (s_wb_stb_o !== v.exp_stb || s_wb_cyc_o !== v.exp_stb) stb_bad = 1;
                if (stb_cnt == 0) begin
                    for (int k = 0; k < NP; k++) begin
                        if (s_wb_adr_o[k*AW +: AW] !== v.adr || s_wb_dat_o[k*DW +: DW] !== v.wdat ||
                            s_wb_sel_o[k*SW +: SW] !== v.sel || s_wb_we_o[k] !== v.we) bc_bad = 1;
                    end
                end
                stb_cnt++;
            end
            if (m_wb_ack_o || m_wb_err_o) begin
                resp_edge = e;
                got_ack = m_wb_ack_o; got_err = m_wb_err_o;
                got_dat = m_wb_dat_o; got_tmo = tmo_o;
                m_cyc = 1'b0; m_stb = 1'b0;
            end
            s_ack = '0;
            s_err = '0;
            if (s_wb_stb_o != '0 && stb_cnt - 1 == v.wt) begin
                s_ack = (v.resp != 1) ? v.exp_stb : 3'b000;
                s_err = (v.resp != 0) ? v.exp_stb : 3'b000;
            end else if (s_wb_stb_o != '0) begin
                // stray ack from a neighbour slave must be ignored
                s_ack = {v.exp_stb[1:0], v.exp_stb[2]};
            end
        end
        s_ack = '0;
        s_err = '0;
        chk($sformatf("v%0d_resp_edge", vi), 64'(resp_edge), 64'(v.exp_edge));
        chk($sformatf("v%0d_ack", vi), 64'(got_ack), 64'(v.exp_ack));
        chk($sformatf("v%0d_err", vi), 64'(got_err), 64'(v.exp_err));
        chk($sformatf("v%0d_dat", vi), 64'(got_dat), 64'(v.exp_dat));
        chk($sformatf("v%0d_tmo", vi), 64'(got_tmo), 64'(0));
        chk($sformatf("v%0d_stb_onehot", vi), 64'(stb_bad), 64'(0));
        chk($sformatf("v%0d_stb_cycles", vi), 64'(stb_cnt), 64'(v.exp_stb == 3'b000 ? 0 : v.wt + 1));
        if (v.exp_stb != 3'b000)
            chk($sformatf("v%0d_broadcast", vi), 64'(bc_bad), 64'(0));
        @(posedge clk); #1;
        chk($sformatf("v%0d_pulse_end", vi), 64'({m_wb_ack_o, m_wb_err_o}), 64'(0));
        chk($sformatf("v%0d_dat_hold", vi), 64'(m_wb_dat_o), 64'(v.exp_dat));
    endtask

    task automatic wait_strobe(input string name, output logic ok);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(posedge clk); #1;
            if (s_wb_stb_o != '0) ok = 1;
        end
        chk(name, 64'(ok), 64'(1));
    endtask

    initial begin
        logic ok;
        logic seen;
        int   stb_cnt;
        int   resp_edge;
        logic got_err, got_ack, got_tmo;

        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0;
        s_dat_i = '0;
        idle_inputs();

        vecs[0] = '{32'h0001_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 0, 0, 32'hA5A5_A5A5, 3'b010, 3, 1'b1, 1'b0, 32'hA5A5_A5A5};
        vecs[1] = '{32'h0002_0000, 32'h0000_0000, 4'hF, 1'b0, 4, 0, 32'h1234_5678, 3'b100, 7, 1'b1, 1'b0, 32'h1234_5678};
        vecs[2] = '{32'h0003_0000, 32'h1111_2222, 4'h3, 1'b1, 0, 0, 32'h9999_9999, 3'b000, 1, 1'b0, 1'b1, 32'h0000_0000};
        vecs[3] = '{32'h0000_0010, 32'h0000_0000, 4'hF, 1'b0, 1, 2, 32'h55AA_55AA, 3'b001, 4, 1'b0, 1'b1, 32'h0000_0000};
        vecs[4] = '{32'h0000_0020, 32'h0000_0000, 4'h1, 1'b0, 2, 0, 32'hCAFE_F00D, 3'b001, 5, 1'b1, 1'b0, 32'hCAFE_F00D};
        vecs[5] = '{32'h0002_FFFC, 32'h0BEE_F00D, 4'hC, 1'b1, 0, 1, 32'h7777_7777, 3'b100, 3, 1'b0, 1'b1, 32'h0000_0000};
        vecs[6] = '{32'h1234_0008, 32'h0000_0000, 4'hF, 1'b0, 0, 0, 32'h0BAD_C0DE, 3'b001, 3, 1'b1, 1'b0, 32'h0BAD_C0DE};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mout", 64'({m_wb_dat_o, m_wb_ack_o, m_wb_err_o, tmo_o}), 64'(0));
        chk("rst_sout", 64'(|{s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_sel_o, s_wb_adr_o, s_wb_dat_o}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // watchdog: slave0 never answers
        m_adr = 32'h0000_0040; m_we = 1'b0; m_sel = 4'hF;
        m_cyc = 1'b1; m_stb = 1'b1;
`ifdef WB_SPLITTER_TIMEOUT_EN
        stb_cnt = 0; resp_edge = -1; got_err = 0; got_ack = 0; got_tmo = 0;
        for (int e = 0; e < 40 && resp_edge < 0; e++) begin
            @(posedge clk); #1;
            if (s_wb_stb_o == 3'b001) stb_cnt++;
            if (m_wb_ack_o || m_wb_err_o) begin
                resp_edge = e;
                got_err = m_wb_err_o; got_ack = m_wb_ack_o; got_tmo = tmo_o;
                m_cyc = 1'b0; m_stb = 1'b0;
            end
        end
        chk("tmo_stb_cycles", 64'(stb_cnt), 64'(16));
        chk("tmo_resp_edge", 64'(resp_edge), 64'(18));
        chk("tmo_err", 64'(got_err), 64'(1));
        chk("tmo_ack", 64'(got_ack), 64'(0));
        chk("tmo_pulse_with_err", 64'(got_tmo), 64'(1));
        @(posedge clk); #1;
        chk("tmo_pulse_end", 64'({tmo_o, m_wb_err_o, s_wb_stb_o}), 64'(0));
`else
        seen = 0; stb_cnt = 0;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk); #1;
            if (tmo_o || m_wb_ack_o || m_wb_err_o) seen = 1;
            if (s_wb_stb_o == 3'b001) stb_cnt++;
        end
        chk("notmo_no_resp", 64'(seen), 64'(0));
        chk("notmo_stb_held", 64'(stb_cnt), 64'(29));
        m_cyc = 1'b0; m_stb = 1'b0;
        @(posedge clk); #1;
        chk("notmo_abort_stb", 64'(s_wb_stb_o), 64'(0));
`endif
        @(posedge clk); #1;

        // master abort in BUSY
        m_adr = 32'h0001_0000; m_cyc = 1'b1; m_stb = 1'b1;
        wait_strobe("abort_stb_up", ok);
        chk("abort_stb_val", 64'(s_wb_stb_o), 64'(3'b010));
        @(posedge clk); #1;
        m_cyc = 1'b0; m_stb = 1'b0;
        @(posedge clk); #1;
        chk("abort_stb_drop", 64'({s_wb_cyc_o, s_wb_stb_o}), 64'(0));
        seen = 0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            if (m_wb_ack_o || m_wb_err_o || s_wb_stb_o != '0) seen = 1;
        end
        chk("abort_no_resp", 64'(seen), 64'(0));

        // reset in the middle of BUSY
        m_adr = 32'h0002_0000; m_cyc = 1'b1; m_stb = 1'b1;
        wait_strobe("rstmid_stb_up", ok);
        chk("rstmid_stb_val", 64'(s_wb_stb_o), 64'(3'b100));
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_async_mout", 64'({m_wb_dat_o, m_wb_ack_o, m_wb_err_o, tmo_o}), 64'(0));
        chk("rstmid_async_sout", 64'(|{s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_sel_o, s_wb_adr_o, s_wb_dat_o}), 64'(0));
        @(posedge clk); #1;
        chk("rstmid_held", 64'(|{s_wb_cyc_o, s_wb_stb_o, m_wb_ack_o, m_wb_err_o, tmo_o, m_wb_dat_o}), 64'(0));
        m_cyc = 1'b0; m_stb = 1'b0;
        #3 rst_n = 1'b1;
        seen = 0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            if (m_wb_ack_o || m_wb_err_o || s_wb_stb_o != '0) seen = 1;
        end
        chk("rstmid_no_resp", 64'(seen), 64'(0));

        // recovery after reset
        run_vec(vecs[0], 10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
